// File: rtl/acq_event_dispatcher_if.sv
// rtl/acq_event_dispatcher_if.sv - event FIFO pop and readout request/ack/done handshake bundle
interface acq_event_dispatcher_if;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready;
  logic        readout_req;
  logic [2:0]  readout_type;
  logic [23:0] readout_num;
  logic        readout_ack;
  logic        readout_done;

  modport master (
    input  evt_valid, evt_data, readout_ack, readout_done,
    output evt_ready, readout_req, readout_type, readout_num
  );

  modport slave (
    output evt_valid, evt_data, readout_ack, readout_done,
    input  evt_ready, readout_req, readout_type, readout_num
  );
endinterface

// File: rtl/acq_event_dispatcher.sv
// rtl/acq_event_dispatcher.sv - pops acquisition events, checks format/sequence, issues one readout per event
// Optional trigger-type filter (type_mask/drop_count) enabled by ACQ_DISPATCH_TYPE_FILTER_EN.
module acq_event_dispatcher #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter int unsigned TNUM_W         = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  acq_event_dispatcher_if.master        bus,
  input  logic                          clear_errors,
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
  input  logic [7:0]                    type_mask,
  output logic [15:0]                   drop_count,
`endif
  output logic                          busy,
  output logic                          seq_err,
  output logic                          fmt_err,
  output logic                          timeout_err,
  output logic [31:0]                   evt_count,
  output logic [15:0]                   skip_count,
  output logic [3:0]                    state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_CHECK   = 4'b0010,
    S_REQUEST = 4'b0100,
    S_WAIT    = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic [2:0]          type_q, type_d;
  logic [TNUM_W-1:0]   num_q, num_d;
  logic                exp_valid_q, exp_valid_d;
  logic [TNUM_W-1:0]   exp_num_q, exp_num_d;
  logic                seq_err_q, seq_err_d;
  logic                fmt_err_q, fmt_err_d;
  logic                timeout_err_q, timeout_err_d;
  logic [31:0]         evt_count_q, evt_count_d;
  logic [15:0]         skip_count_q, skip_count_d;
  logic [23:0]         tmo_cnt_q, tmo_cnt_d;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
  logic [15:0]         drop_count_q, drop_count_d;
`endif

  logic                fmt_bad;
  logic                seq_bad;
  logic [2:0]          type_w;
  logic [TNUM_W-1:0]   num_w;

  assign fmt_bad = |word_q[31:27];
  assign type_w  = word_q[26:24];
  assign num_w   = word_q[TNUM_W-1:0];
  assign seq_bad = exp_valid_q && (num_w != exp_num_q);

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    type_d        = type_q;
    num_d         = num_q;
    exp_valid_d   = exp_valid_q;
    exp_num_d     = exp_num_q;
    evt_count_d   = evt_count_q;
    tmo_cnt_d     = tmo_cnt_q;
    // Clear is applied first so an error raised in the same cycle overrides it.
    seq_err_d     = clear_errors ? 1'b0  : seq_err_q;
    fmt_err_d     = clear_errors ? 1'b0  : fmt_err_q;
    timeout_err_d = clear_errors ? 1'b0  : timeout_err_q;
    skip_count_d  = clear_errors ? 16'd0 : skip_count_q;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
    drop_count_d  = clear_errors ? 16'd0 : drop_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.evt_valid) begin
          word_d  = bus.evt_data;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (fmt_bad) begin
          fmt_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          if (seq_bad) begin
            seq_err_d = 1'b1;
            if (skip_count_d != 16'hFFFF) skip_count_d = skip_count_d + 16'd1;
          end
          exp_num_d   = num_w + TNUM_W'(1);
          exp_valid_d = 1'b1;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
          if (!type_mask[type_w]) begin
            if (drop_count_d != 16'hFFFF) drop_count_d = drop_count_d + 16'd1;
            state_d = S_IDLE;
          end else begin
            type_d  = type_w;
            num_d   = num_w;
            state_d = S_REQUEST;
          end
`else
          type_d  = type_w;
          num_d   = num_w;
          state_d = S_REQUEST;
`endif
        end
      end

      S_REQUEST: begin
        // readout_done is deliberately not looked at until the request is acked.
        if (bus.readout_ack) begin
          evt_count_d = evt_count_q + 32'd1;
          tmo_cnt_d   = 24'd0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.readout_done) begin
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      word_q        <= 32'd0;
      type_q        <= 3'd0;
      num_q         <= '0;
      exp_valid_q   <= 1'b0;
      exp_num_q     <= '0;
      seq_err_q     <= 1'b0;
      fmt_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      evt_count_q   <= 32'd0;
      skip_count_q  <= 16'd0;
      tmo_cnt_q     <= 24'd0;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
      drop_count_q  <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      type_q        <= type_d;
      num_q         <= num_d;
      exp_valid_q   <= exp_valid_d;
      exp_num_q     <= exp_num_d;
      seq_err_q     <= seq_err_d;
      fmt_err_q     <= fmt_err_d;
      timeout_err_q <= timeout_err_d;
      evt_count_q   <= evt_count_d;
      skip_count_q  <= skip_count_d;
      tmo_cnt_q     <= tmo_cnt_d;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
      drop_count_q  <= drop_count_d;
`endif
    end
  end

  // Request is a decode of the state flop, so it drops as soon as reset lands.
  assign bus.evt_ready    = (state_q == S_IDLE);
  assign bus.readout_req  = (state_q == S_REQUEST);
  assign bus.readout_type = type_q;
  assign bus.readout_num  = num_q;

  assign busy        = (state_q != S_IDLE);
  assign state       = state_q;
  assign seq_err     = seq_err_q;
  assign fmt_err     = fmt_err_q;
  assign timeout_err = timeout_err_q;
  assign evt_count   = evt_count_q;
  assign skip_count  = skip_count_q;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_acq_event_dispatcher.sv
// tb/tb_acq_event_dispatcher.sv - randomized bench with a transaction-level dispatcher model
module tb_acq_event_dispatcher;
  localparam int TMO = 16;
  localparam logic [3:0] ST_IDLE = 4'b0001, ST_CHECK = 4'b0010, ST_REQ = 4'b0100, ST_WAIT = 4'b1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_errors = 1'b0;
  logic        busy, seq_err, fmt_err, timeout_err;
  logic [31:0] evt_count;
  logic [15:0] skip_count;
  logic [3:0]  state;
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
  logic [7:0]  type_mask = 8'hFF;
  logic [15:0] drop_count;
`endif

  acq_event_dispatcher_if bus();

  acq_event_dispatcher #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .clear_errors (clear_errors),
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
    .type_mask    (type_mask),
    .drop_count   (drop_count),
`endif
    .busy         (busy),
    .seq_err      (seq_err),
    .fmt_err      (fmt_err),
    .timeout_err  (timeout_err),
    .evt_count    (evt_count),
    .skip_count   (skip_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;

  // Model of what the outside world must observe.
  bit          m_chk_en = 1'b0;
  logic [3:0]  m_state = ST_IDLE;
  bit          m_seq = 1'b0, m_fmt = 1'b0, m_tmo = 1'b0;
  int unsigned m_evt = 0, m_skip = 0, m_drop = 0;
  bit          m_exp_valid = 1'b0;
  logic [23:0] m_exp = 24'd0;
  logic [2:0]  m_type = 3'd0;
  logic [23:0] m_num = 24'd0;
  logic [7:0]  m_mask = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_chk_en) begin
      check("state", 32'(state), 32'(m_state));
      check("busy", 32'(busy), 32'(m_state != ST_IDLE));
      check("evt_ready", 32'(bus.evt_ready), 32'(m_state == ST_IDLE));
      check("readout_req", 32'(bus.readout_req), 32'(m_state == ST_REQ));
      if (m_state == ST_REQ) begin
        check("readout_type", 32'(bus.readout_type), 32'(m_type));
        check("readout_num", 32'(bus.readout_num), 32'(m_num));
      end
      check("seq_err", 32'(seq_err), 32'(m_seq));
      check("fmt_err", 32'(fmt_err), 32'(m_fmt));
      check("timeout_err", 32'(timeout_err), 32'(m_tmo));
      check("evt_count", evt_count, m_evt);
      check("skip_count", 32'(skip_count), m_skip);
`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
      check("drop_count", 32'(drop_count), m_drop);
`endif
    end
  end

  task automatic model_reset();
    m_state = ST_IDLE; m_seq = 1'b0; m_fmt = 1'b0; m_tmo = 1'b0;
    m_evt = 0; m_skip = 0; m_drop = 0; m_exp_valid = 1'b0; m_exp = 24'd0;
  endtask

  task automatic model_clear();
    m_seq = 1'b0; m_fmt = 1'b0; m_tmo = 1'b0; m_skip = 0; m_drop = 0;
  endtask

  // Judge one popped word: new errors override a simultaneous clear.
  task automatic model_check(input logic [31:0] w, input bit clr, output bit dispatch);
    bit fmt_new, seq_new, drop_new;
    fmt_new  = (w[31:27] != 5'd0);
    seq_new  = !fmt_new && m_exp_valid && (w[23:0] != m_exp);
    drop_new = !fmt_new && !m_mask[w[26:24]];
    if (clr) model_clear();
    if (fmt_new) m_fmt = 1'b1;
    if (seq_new) begin
      m_seq = 1'b1;
      if (m_skip < 65535) m_skip++;
    end
    if (!fmt_new) begin
      m_exp = w[23:0] + 24'd1;
      m_exp_valid = 1'b1;
    end
    if (drop_new && m_drop < 65535) m_drop++;
    dispatch = !fmt_new && !drop_new;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    m_chk_en = 1'b0;
    reset_n = 1'b0;
    tick();
    model_reset();
    reset_n = 1'b1;
    m_chk_en = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    model_clear();
  endtask

  // Called with the DUT idle, just after a clock edge.
  task automatic run_event(input logic [31:0] w, input int ack_dly, input bit ack_done,
                           input int done_dly, input bit clr, input bit abort);
    bit dispatch;
    bus.evt_valid = 1'b1;
    bus.evt_data  = w;
    tick();
    bus.evt_valid = 1'b0;
    bus.evt_data  = $urandom;
    m_state = ST_CHECK;
    clear_errors = clr;
    tick();
    clear_errors = 1'b0;
    model_check(w, clr, dispatch);
    if (!dispatch) begin
      m_state = ST_IDLE;
    end else begin
      m_state = ST_REQ;
      m_type  = w[26:24];
      m_num   = w[23:0];
      if (abort) begin
        m_chk_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_readout_req", 32'(bus.readout_req), 32'd0);
        check("rst_state", 32'(state), 32'h1);
        check("rst_evt_count", evt_count, 32'd0);
        tick();
        model_reset();
        reset_n = 1'b1;
        m_chk_en = 1'b1;
      end else begin
        repeat (ack_dly) tick();
        bus.readout_ack  = 1'b1;
        bus.readout_done = ack_done;
        tick();
        bus.readout_ack  = 1'b0;
        bus.readout_done = 1'b0;
        m_evt++;
        m_state = ST_WAIT;
        if (done_dly < TMO) begin
          repeat (done_dly) tick();
          bus.readout_done = 1'b1;
          tick();
          bus.readout_done = 1'b0;
          m_state = ST_IDLE;
        end else begin
          repeat (TMO) tick();
          m_state = ST_IDLE;
          m_tmo = 1'b1;
        end
      end
    end
  endtask

  initial begin
    bus.evt_valid = 1'b0; bus.evt_data = 32'd0;
    bus.readout_ack = 1'b0; bus.readout_done = 1'b0;
    repeat (2) tick();
    check("reset_state", 32'(state), 32'h1);
    check("reset_req", 32'(bus.readout_req), 32'd0);
    check("reset_ready", 32'(bus.evt_ready), 32'd1);
    check("reset_evt_count", evt_count, 32'd0);
    reset_n = 1'b1;
    m_chk_en = 1'b1;

    // Two in-order events.
    run_event(32'h0000_0005, 1, 1'b0, 2, 1'b0, 1'b0);
    run_event(32'h0000_0006, 1, 1'b0, 2, 1'b0, 1'b0);
    check("t1_evt_count", evt_count, 32'd2);
    check("t1_seq_err", 32'(seq_err), 32'd0);

    // Gap in the sequence, then clear.
    do_reset();
    run_event(32'h0000_000A, 0, 1'b0, 0, 1'b0, 1'b0);
    run_event(32'h0000_000C, 2, 1'b1, 3, 1'b0, 1'b0);
    check("t2_seq_err", 32'(seq_err), 32'd1);
    check("t2_skip_count", 32'(skip_count), 32'd1);
    check("t2_evt_count", evt_count, 32'd2);
    pulse_clear();
    check("t2_seq_clr", 32'(seq_err), 32'd0);
    check("t2_skip_clr", 32'(skip_count), 32'd0);

    // Wrap of the trigger number, then a malformed word.
    do_reset();
    run_event(32'h00FF_FFFF, 0, 1'b0, 1, 1'b0, 1'b0);
    run_event(32'h0000_0000, 0, 1'b0, 1, 1'b0, 1'b0);
    check("t3_wrap_seq", 32'(seq_err), 32'd0);
    run_event(32'h0800_0001, 0, 1'b0, 1, 1'b0, 1'b0);
    check("t3_fmt_err", 32'(fmt_err), 32'd1);
    check("t3_evt_count", evt_count, 32'd2);

    // Timeout, then done on the last allowed cycle.
    run_event(32'h0000_0001, 0, 1'b0, TMO, 1'b0, 1'b0);
    check("t4_timeout", 32'(timeout_err), 32'd1);
    check("t4_idle", 32'(state), 32'h1);
    pulse_clear();
    run_event(32'h0000_0002, 0, 1'b0, TMO - 1, 1'b0, 1'b0);
    check("t4_done_wins", 32'(timeout_err), 32'd0);

    // Reset during REQUEST, then sequence restarts.
    run_event(32'h0000_0003, 0, 1'b0, 0, 1'b0, 1'b1);
    run_event(32'h0000_0064, 0, 1'b0, 0, 1'b0, 1'b0);
    check("t5_seq_after_rst", 32'(seq_err), 32'd0);
    check("t5_evt_count", evt_count, 32'd1);

`ifdef ACQ_DISPATCH_TYPE_FILTER_EN
    m_mask = 8'h02; type_mask = m_mask;
    run_event({5'd0, 3'd1, 24'd101}, 0, 1'b0, 0, 1'b0, 1'b0);
    run_event({5'd0, 3'd3, 24'd102}, 0, 1'b0, 0, 1'b0, 1'b0);
    check("tf_drop_count", 32'(drop_count), 32'd1);
    check("tf_evt_count", evt_count, 32'd2);
    m_mask = 8'hB7; type_mask = m_mask;
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      logic [23:0] n;
      int r;
      r = int'($urandom_range(0, 15));
      if (!m_exp_valid || (r >= 10 && r < 12)) n = 24'($urandom);
      else if (r < 10) n = m_exp;
      else if (r == 12) n = 24'hFF_FFFF;
      else n = m_exp + 24'($urandom_range(1, 3));
      w = {5'd0, 3'($urandom_range(0, 7)), n};
      if ($urandom_range(0, 11) == 0) w[31:27] = 5'($urandom_range(1, 31));
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 9) == 0) pulse_clear();
        else tick();
      end
      run_event(w, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 18)), ($urandom_range(0, 9) == 0), 1'b0);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
